// File: rtl/button_ctrl_multi.sv
// ---------------------------------------------------------------------------
// button_ctrl_multi
//
// N-channel debounced push-button controller. Each channel synchronises its
// raw button, debounces press and release, and steps a modular up/down
// setting counter once per accepted press. Holding a button past HOLD_CYCLES
// enters auto-repeat, which steps every REPEAT_CYCLES until release.
//
// Channel i uses MAX_VALS[i*CNT_W +: CNT_W] as its wrap limit and
// INIT_VALS[i*CNT_W +: CNT_W] as its reset value. value and step_pulse are
// updated on the same clock edge, so step_pulse marks exactly the cycle on
// which the new counter value first appears.
// ---------------------------------------------------------------------------
module button_ctrl_multi #(
  parameter int                         NUM_BTN         = 3,
  parameter int                         CNT_W           = 4,
  parameter logic [NUM_BTN*CNT_W-1:0]   MAX_VALS        = {4'd0, 4'd4, 4'd11},
  parameter logic [NUM_BTN*CNT_W-1:0]   INIT_VALS       = {4'd0, 4'd4, 4'd0},
  parameter int                         DEBOUNCE_CYCLES = 100000,
  parameter int                         HOLD_CYCLES     = 50000000,
  parameter int                         REPEAT_CYCLES   = 10000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BTN-1:0]         btn_in,
  input  logic [NUM_BTN-1:0]         btn_dn,
  output logic [NUM_BTN*CNT_W-1:0]   value,
  output logic [NUM_BTN-1:0]         step_pulse,
  output logic [NUM_BTN-1:0]         repeat_active
);

  // -------------------------------------------------------------------------
  // Timer sizing: the shared per-channel counter only ever counts up to
  // (longest interval - 1), so clog2 of the longest interval is enough.
  // -------------------------------------------------------------------------
  localparam int MAX_DH  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
  localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  // Per-channel FSM encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DEB_PRESS = 3'd1;
  localparam logic [2:0] ST_PRESSED   = 3'd2;
  localparam logic [2:0] ST_REPEAT    = 3'd3;
  localparam logic [2:0] ST_DEB_REL   = 3'd4;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser for every raw button; only sync_q2 is used below.
  // -------------------------------------------------------------------------
  logic [NUM_BTN-1:0] sync_q1;
  logic [NUM_BTN-1:0] sync_q2;

  // Capture the asynchronous buttons into the clock domain
  // NOTE: sequential state always uses non-blocking (<=) so every flop sees
  // the pre-edge value of its neighbours, which is what makes the two-flop
  // chain a real two-stage delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  // -------------------------------------------------------------------------
  // Independent channel instances
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    localparam logic [CNT_W-1:0] MAX_V  = MAX_VALS[i*CNT_W +: CNT_W];
    localparam logic [CNT_W-1:0] INIT_V = INIT_VALS[i*CNT_W +: CNT_W];

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             step_d;
    logic             step_q;
    logic             rep_q;
    logic [CNT_W-1:0] val_q;
    logic [CNT_W-1:0] val_nxt;
    logic             pressed;

    assign pressed = sync_q2[i];

    // Debounce / hold / repeat sequencing and step generation
    // NOTE: every signal assigned in this always_comb gets a default first,
    // so no path through the case statement can infer a latch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      step_d  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (pressed) state_d = ST_DEB_PRESS;
        end
        ST_DEB_PRESS: begin
          if (!pressed) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
            step_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_PRESSED: begin
          if (!pressed) begin
            state_d = ST_DEB_REL;
            cnt_d   = '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = ST_REPEAT;
            cnt_d   = '0;
            step_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_REPEAT: begin
          if (!pressed) begin
            state_d = ST_DEB_REL;
            cnt_d   = '0;
          end else if (cnt_q == REP_LAST) begin
            cnt_d  = '0;
            step_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DEB_REL: begin
          // A short release glitch returns to PRESSED without a step and
          // restarts the hold timer from zero.
          if (pressed) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Modular next value; with MAX_V == 0 both directions land on 0 again
    always_comb begin
      val_nxt = val_q;
      if (val_q > MAX_V) begin
        val_nxt = INIT_V;
      end else if (btn_dn[i]) begin
        val_nxt = (val_q == '0) ? MAX_V : val_q - CNT_W'(1);
      end else begin
        val_nxt = (val_q == MAX_V) ? '0 : val_q + CNT_W'(1);
      end
    end

    // Channel state, counter value and registered status outputs
    // NOTE: reset is synchronous and clears every register here, including
    // the timer, so a reset mid-debounce or mid-repeat leaves no residue.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        val_q   <= INIT_V;
        step_q  <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        step_q  <= step_d;
        rep_q   <= (state_d == ST_REPEAT);
        if (step_d) val_q <= val_nxt;
      end
    end

    assign value[i*CNT_W +: CNT_W] = val_q;
    assign step_pulse[i]           = step_q;
    assign repeat_active[i]        = rep_q;
  end

endmodule

// File: tb/tb_button_ctrl_multi.sv
// ---------------------------------------------------------------------------
// tb_button_ctrl_multi
//
// Directed bench for button_ctrl_multi with short timing parameters.
// Channel 0: MAX 11, INIT 0. Channel 1: MAX 4, INIT 4.
// Timing reference: pc is the cycle number right after the first clock edge
// that samples btn_in high; the press step is seen at pc+6 (2 sync + 4
// debounce), the first repeat at pc+26 (+20 hold), then every 8 cycles.
// ---------------------------------------------------------------------------
module tb_button_ctrl_multi;

  localparam int NUM_BTN = 2;
  localparam int CNT_W   = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_BTN-1:0]       btn_in;
  logic [NUM_BTN-1:0]       btn_dn;
  logic [NUM_BTN*CNT_W-1:0] value;
  logic [NUM_BTN-1:0]       step_pulse;
  logic [NUM_BTN-1:0]       repeat_active;

  int checks = 0;
  int errors = 0;

  button_ctrl_multi #(
    .NUM_BTN         (NUM_BTN),
    .CNT_W           (CNT_W),
    .MAX_VALS        ({4'd4, 4'd11}),
    .INIT_VALS       ({4'd4, 4'd0}),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_in        (btn_in),
    .btn_dn        (btn_dn),
    .value         (value),
    .step_pulse    (step_pulse),
    .repeat_active (repeat_active)
  );

  always #5 clk = ~clk;

  // Free-running cycle number, bumped on every rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log: cycle numbers of every step pulse / repeat_active cycle
  int q0[$];
  int q1[$];
  int qr[$];
  always @(negedge clk) begin
    if (step_pulse[0])    q0.push_back(cyc);
    if (step_pulse[1])    q1.push_back(cyc);
    if (repeat_active[0]) qr.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int at(input int q[$], input int idx);
    return (idx >= 0 && idx < q.size()) ? q[idx] : -1;
  endfunction

  // Short press (8 cycles) on one channel, then release and settle
  task automatic press_one(input int ch, input logic dn, input int exp_val, input string tag);
    int b;
    int pc;
    int n;
    int t;
    b  = (ch == 0) ? q0.size() : q1.size();
    pc = cyc + 1;
    btn_dn[ch] = dn;
    btn_in[ch] = 1'b1;
    tick(8);
    btn_in[ch] = 1'b0;
    tick(14);
    n = (ch == 0) ? q0.size() - b : q1.size() - b;
    t = (ch == 0) ? at(q0, b) : at(q1, b);
    check({tag, "_nsteps"}, n, 1);
    check({tag, "_time"}, t, pc + 6);
    check({tag, "_val"}, value[ch*CNT_W +: CNT_W], exp_val);
  endtask

  int b0;
  int b1;
  int br;
  int pc;
  int hold_exp[6]   = '{6, 26, 34, 42, 50, 58};
  int glitch_exp[4] = '{6, 39, 47, 55};

  initial begin
    reset  = 1'b1;
    btn_in = '0;
    btn_dn = '0;
    tick(3);
    check("rst_value", value, 8'h40);
    reset = 1'b0;
    tick(1);
    check("post_rst_value", value, 8'h40);
    check("post_rst_step", step_pulse, 0);
    check("post_rst_repeat", repeat_active, 0);

    // Reset asserted while channel 0 is in DEB_PRESS: no step must follow
    b0 = q0.size();
    btn_in[0] = 1'b1;
    tick(4);
    reset     = 1'b1;
    btn_in[0] = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(12);
    check("midrst_nsteps", q0.size() - b0, 0);
    check("midrst_value", value, 8'h40);

    // Clean 10-cycle press on ch0, up: one step at pc+6, none on release
    b0 = q0.size();
    b1 = q1.size();
    pc = cyc + 1;
    btn_in[0] = 1'b1;
    tick(4);
    check("clean_val_before", value[3:0], 0);
    tick(6);
    btn_in[0] = 1'b0;
    tick(20);
    check("clean_nsteps", q0.size() - b0, 1);
    check("clean_time", at(q0, b0), pc + 6);
    check("clean_val", value[3:0], 1);
    check("clean_ch1_quiet", q1.size() - b1, 0);

    // 2-cycle glitch: shorter than debounce, no step
    b0 = q0.size();
    btn_in[0] = 1'b1;
    tick(2);
    btn_in[0] = 1'b0;
    tick(20);
    check("glitch_nsteps", q0.size() - b0, 0);
    check("glitch_val", value[3:0], 1);

    // Wrap checks: ch0 down 1->0->11, up 11->0; ch1 up 4->0, down 0->4, up 4->0
    press_one(0, 1'b1, 0,  "ch0_dn_1to0");
    press_one(0, 1'b1, 11, "ch0_dn_wrap");
    press_one(0, 1'b0, 0,  "ch0_up_wrap");
    press_one(1, 1'b0, 0,  "ch1_up_wrap");
    press_one(1, 1'b1, 4,  "ch1_dn_wrap");
    press_one(1, 1'b0, 0,  "ch1_up_wrap2");

    // 60-cycle hold on ch0, up from 0: press step + five repeats
    b0 = q0.size();
    br = qr.size();
    pc = cyc + 1;
    btn_dn[0] = 1'b0;
    btn_in[0] = 1'b1;
    tick(60);
    btn_in[0] = 1'b0;
    tick(20);
    check("hold_nsteps", q0.size() - b0, 6);
    for (int k = 0; k < 6; k++)
      check($sformatf("hold_step%0d", k), at(q0, b0 + k), pc + hold_exp[k]);
    check("hold_val", value[3:0], 6);
    check("hold_rep_first", at(qr, br), pc + 26);
    check("hold_rep_last", at(qr, qr.size() - 1), pc + 61);
    check("hold_rep_len", qr.size() - br, 36);
    check("hold_rep_low", repeat_active, 0);

    // Hold with a 2-cycle low glitch (samples 15,16): hold timer restarts
    b0 = q0.size();
    br = qr.size();
    pc = cyc + 1;
    btn_in[0] = 1'b1;
    tick(15);
    btn_in[0] = 1'b0;
    tick(2);
    btn_in[0] = 1'b1;
    tick(43);
    btn_in[0] = 1'b0;
    tick(20);
    check("hglitch_nsteps", q0.size() - b0, 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("hglitch_step%0d", k), at(q0, b0 + k), pc + glitch_exp[k]);
    check("hglitch_rep_first", at(qr, br), pc + 39);
    check("hglitch_val", value[3:0], 10);

    // Both channels pressed together, ch0 up 10->11, ch1 down 0->4 (wrap)
    b0 = q0.size();
    b1 = q1.size();
    pc = cyc + 1;
    btn_dn = 2'b10;
    btn_in = 2'b11;
    tick(8);
    btn_in = 2'b00;
    tick(14);
    check("both_n0", q0.size() - b0, 1);
    check("both_n1", q1.size() - b1, 1);
    check("both_t0", at(q0, b0), pc + 6);
    check("both_t1", at(q1, b1), pc + 6);
    check("both_value", value, 8'h4B);

    // Final reset restores initial values
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    check("final_rst_value", value, 8'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
